m_seven_seg_scanner: RTL
========================

// Module: m_seven_seg_scanner
// PURPOSE
//  Time-multiplexes NUM_DIGITS common-anode 7-seg digits through one shared
//  combinational m_hex_decoder. Holds a display word, presents one nibble at a
//  time on nibble_out, registers the returned pattern plus decimal point onto
//  seg, and drives active-low anodes. It inserts blanking gaps between digits
//  and applies new values only at frame start, so a digit never shows a
//  partial update.
// PARAMETERS
//  NUM_DIGITS    4       digits scanned; digit 0 = value[3:0], an[0]
//  REFRESH_DIV   100000  clk cycles per digit slot (BLANK + SHOW); > BLANK_CYCLES+1
//  BLANK_CYCLES  16      cycles with all anodes off at the start of each slot; >= 1
// PORTS
//  clk         in   1            system clock, rising edge
//  rst         in   1            asynchronous, active-high reset
//  en          in   1            1 = scan; 0 = display dark
//  load        in   1            1-cycle strobe: capture value/dp_mask into pending
//  value       in   4*NUM_DIGITS hex nibbles to display
//  dp_mask     in   NUM_DIGITS   1 = light decimal point of that digit
//  digit_en    in   NUM_DIGITS   1 = digit shown; 0 = anode kept off (suppression)
//  nibble_out  out  4            to decoder input; = disp[digit] (combinational)
//  seg_in      in   8            from decoder output, active-low, bit7 = DP
//  seg         out  8            registered segments, active-low
//  an          out  NUM_DIGITS   registered anodes, active-low one-hot or all-1
//  load_ack    out  1            1-cycle pulse when pending is committed to disp
//  frame_done  out  1            1-cycle pulse at end of the last digit's SHOW
// BEHAVIOUR
//  Reset (async): state=IDLE, digit=0, cnt=0, an=all 1, seg=8'hFF, load_ack=0,
//   frame_done=0, disp/disp_dp=0, pending=0, pend_valid=0.
//  Registers: cnt width $clog2(REFRESH_DIV); digit width $clog2(NUM_DIGITS) (min 1).
//  load: pending<=value, pend_dp<=dp_mask, pend_valid<=1. A later load overwrites
//   it (last wins). Commit: disp<=pending, pend_valid<=0, load_ack=1 for 1 cycle.
//   When a load coincides with a commit, the old pending commits, the new value
//   is captured, and pend_valid stays 1.
//  Commit points: every cycle in IDLE, and on each transition into BLANK
//   with digit=0, so disp is already new during that BLANK.
//  IDLE: an=all 1, seg=8'hFF. If en: go to BLANK with digit=0 and cnt=0.
//  BLANK: an=all 1. Lasts BLANK_CYCLES cycles. On the last cycle, seg<= {seg_in[7] &
//   ~disp_dp[digit], seg_in[6:0]}. Then go to SHOW with cnt=0.
//  SHOW: an[digit]=0 if digit_en[digit], else an=all 1. Lasts REFRESH_DIV-BLANK_CYCLES
//   cycles. Then go to BLANK with digit+1; at NUM_DIGITS-1, wrap to 0 and pulse
//   frame_done.
//  en=0 in BLANK or SHOW: the next cycle is IDLE with an=all 1, seg=8'hFF, digit=0,
//   cnt=0. No frame_done pulse.
//  Frame period = NUM_DIGITS*REFRESH_DIV cycles; anode duty per digit =
//   (REFRESH_DIV-BLANK_CYCLES)/REFRESH_DIV.
//  Under no circumstance are two anodes low together. an=all 1 holds for at least
//   BLANK_CYCLES between slots.
//  rst mid-frame: outputs go to their reset values immediately; pending load is lost.
// TESTING  (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, digit_en=4'hF)
//  1. Assert rst while scanning -> an=4'hF, seg=8'hFF, load_ack=0 at once,
//   without waiting for a clock edge; these values hold until rst is released.
//  2. Load value=16'h12AF with dp_mask=0, then en=1 -> an follows 4'hF x2, 4'hE x6,
//   4'hF x2, 4'hD x6, 4'hF x2, 4'hB x6, 4'hF x2, 4'h7 x6. seg is 8'h8E, 8'h88,
//   8'hA4, 8'hF9. frame_done pulses every 32 cycles.
//  3. dp_mask=4'b0010 -> digit1 seg=8'h08; other digits are unchanged.
//   digit_en=4'b0011 -> an[3:2] stay 1 for the whole frame.
//  4. Mid-frame load 16'h0000, then load 16'h3333 -> the digits stay on 12AF until
//   the frame ends. At the next digit-0 BLANK entry, exactly one load_ack pulse
//   occurs and all digits show 8'hB0.
//  5. load asserted on the same cycle as a commit -> the old pending is acked now;
//   the new value commits at the following frame start with a second ack.
//  6. en=0 during SHOW -> next cycle an=4'hF, seg=8'hFF. en=1 again -> restart at
//   digit 0 BLANK. Check that no cycle ever has more than one an bit low.

Source files
------------

// File: rtl/m_seven_seg_scanner.sv
// m_seven_seg_scanner: time-multiplexed driver for common-anode 7-seg digits.
// Ports: clk/rst, en, load+value+dp_mask, digit_en -> nibble_out/seg_in
//   decoder loop, registered seg/an, load_ack and frame_done pulses.
module m_seven_seg_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [3:0]              nibble_out,
  input  logic [7:0]              seg_in,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    load_ack,
  output logic                    frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  =
    CW'(REFRESH_DIV - BLANK_CYCLES - 1);
  localparam logic [DW-1:0] DIG_LAST   = DW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_SHOW
  } state_t;

  state_t                  state_q, state_d;
  logic [DW-1:0]           digit_q, digit_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    ack_q, ack_d;
  logic                    fd_q, fd_d;

  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_valid_q, pend_valid_d;

  logic                    commit;
  logic [3:0]              nib_sel;
  logic                    dp_sel;

  // Current digit's nibble and decimal-point bit out of the display word.
  always_comb begin
    nib_sel = 4'h0;
    dp_sel  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_q == DW'(i)) begin
        nib_sel = disp_q[4*i +: 4];
        dp_sel  = disp_dp_q[i];
      end
    end
  end

  assign nibble_out = nib_sel;

  // Scan sequencing: IDLE -> (BLANK -> SHOW) per digit, wrapping per frame.
  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    cnt_d   = cnt_q;
    seg_d   = seg_q;
    fd_d    = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        commit  = 1'b1;
        seg_d   = 8'hFF;
        digit_d = '0;
        cnt_d   = '0;
        if (en) begin
          state_d = S_BLANK;
        end
      end
      S_BLANK: begin
        if (!en) begin
          state_d = S_IDLE;
          digit_d = '0;
          cnt_d   = '0;
          seg_d   = 8'hFF;
        end else if (cnt_q == BLANK_LAST) begin
          // Latch the pattern while dark so SHOW starts clean.
          seg_d   = {seg_in[7] & ~dp_sel, seg_in[6:0]};
          state_d = S_SHOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SHOW: begin
        if (!en) begin
          state_d = S_IDLE;
          digit_d = '0;
          cnt_d   = '0;
          seg_d   = 8'hFF;
        end else if (cnt_q == SHOW_LAST) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          if (digit_q == DIG_LAST) begin
            digit_d = '0;
            fd_d    = 1'b1;
            // New frame: swap in pending so every digit shows it.
            commit  = 1'b1;
          end else begin
            digit_d = digit_q + DW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        digit_d = '0;
        cnt_d   = '0;
        seg_d   = 8'hFF;
      end
    endcase
  end

  // Anodes follow the next state so they line up with state_q.
  always_comb begin
    an_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((state_d == S_SHOW) && (digit_d == DW'(i)) && digit_en[i]) begin
        an_d[i] = 1'b0;
      end
    end
  end

  // Pending/display buffering; a coincident load lands after the commit.
  always_comb begin
    disp_d       = disp_q;
    disp_dp_d    = disp_dp_q;
    pend_d       = pend_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    ack_d        = 1'b0;
    if (commit && pend_valid_q) begin
      disp_d       = pend_q;
      disp_dp_d    = pend_dp_q;
      pend_valid_d = 1'b0;
      ack_d        = 1'b1;
    end
    if (load) begin
      pend_d       = value;
      pend_dp_d    = dp_mask;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      digit_q      <= '0;
      cnt_q        <= '0;
      seg_q        <= 8'hFF;
      an_q         <= '1;
      ack_q        <= 1'b0;
      fd_q         <= 1'b0;
      disp_q       <= '0;
      disp_dp_q    <= '0;
      pend_q       <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      digit_q      <= digit_d;
      cnt_q        <= cnt_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      ack_q        <= ack_d;
      fd_q         <= fd_d;
      disp_q       <= disp_d;
      disp_dp_q    <= disp_dp_d;
      pend_q       <= pend_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign load_ack   = ack_q;
  assign frame_done = fd_q;

endmodule
